// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, 1-cycle synchronous icache interface
// and a DEPTH-entry instruction/PC queue drained by decode via valid/ready.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [XLEN-1:0]              icache_addr,
    output logic                         icache_re,
    input  logic [31:0]                  icache_dout,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [XLEN-1:0]              out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
    localparam logic [CW-1:0] FULL_C  = DEPTH[CW-1:0];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];

    logic        pop, push, issue;
    logic [CW:0] occ;

    assign out_valid   = (count_q != '0);
    assign out_instr   = instr_q[head_q];
    assign out_pc      = pc_q[head_q];
    assign count       = count_q;
    assign icache_addr = redirect_valid ? redirect_pc : fetch_pc_q;

    // Credit check counts the in-flight response, so a push can never find the queue full.
    assign pop   = out_valid & out_ready & ~stall;
    assign occ   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue = ~stall & (redirect_valid | (occ < DEPTH_W));
    assign push  = inflight_q & ~stall & ~redirect_valid;
    // Gated by reset so no request leaves the block while it is held in reset.
    assign icache_re = issue & reset;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (!stall) begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = icache_addr;
                fetch_pc_d    = icache_addr + XLEN'(4);
            end else begin
                inflight_d    = 1'b0;
            end
            if (redirect_valid) begin
                count_d = '0;
                head_d  = tail_q;
            end else begin
                if (push) tail_d = tail_q + PW'(1);
                if (pop)  head_d = head_q + PW'(1);
                count_d = count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            if (push) begin
                instr_q[tail_q] <= icache_dout;
                pc_q[tail_q]    <= inflight_pc_q;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && push) assert (count_q != FULL_C);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue of expected head PCs is filled by
// the stimulus process and drained by a monitor on every accepted queue entry.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_2000)) dut (
        .clk(clk), .reset(reset),
        .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    // Icache model: the instruction word at address a is ~a; output held while stalled.
    always @(posedge clk) if (!stall) icache_dout <= ~icache_addr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every entry accepted by decode must match the scoreboard front.
    always @(negedge clk) begin
        #2;
        if (reset && !stall && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", out_pc, mon_e);
                chk("pop_instr", out_instr, ~mon_e);
                $display("pop pc=%h instr=%h", out_pc, out_instr);
            end
        end
    end

    // Asserts reset at a negedge, checks reset outputs, releases it two cycles later.
    task automatic begin_test(input logic rdy);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = rdy;
        #1;
        chk("drained", exp_q.size(), 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_re", icache_re, 0);
        chk("rst_addr", icache_addr, 32'h2000);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // Streaming from reset with decode always ready.
        begin_test(1'b1);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'h2000 + 4 * i);
        for (int c = 1; c <= 12; c++) begin
            #1;
            chk("t1_re", icache_re, 1);
            chk("t1_addr", icache_addr, 32'h2000 + 4 * (c - 1));
            chk("t1_valid", out_valid, (c >= 3) ? 1 : 0);
            if (c >= 3) chk("t1_count", count, 1);
            @(negedge clk);
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Decode not ready: fill to DEPTH, then steady full stream.
        begin_test(1'b0);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h2000 + 4 * i);
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("t2_re", icache_re, (c <= 4) ? 1 : 0);
            chk("t2_addr", icache_addr, 32'h2000 + 4 * ((c <= 5) ? c - 1 : 4));
            chk("t2_count", count, (c <= 2) ? 0 : c - 2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_resume_re", icache_re, 1);
        chk("t2_resume_addr", icache_addr, 32'h2010);
        chk("t2_full_count", count, 4);
        @(negedge clk);
        for (int c = 8; c <= 22; c++) begin
            #1;
            chk("t2_stream_count", count, 3);
            chk("t2_stream_re", icache_re, 1);
            @(negedge clk);
        end
        out_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Redirect with three queued entries and one fetch in flight.
        begin_test(1'b0);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h3000 + 4 * i);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        #1;
        chk("t3_pre_count", count, 3);
        chk("t3_redir_re", icache_re, 1);
        chk("t3_redir_addr", icache_addr, 32'h3000);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t3_flush_count", count, 0);
        chk("t3_flush_valid", out_valid, 0);
        chk("t3_next_addr", icache_addr, 32'h3004);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("t3_head_valid", out_valid, 1);
        chk("t3_head_pc", out_pc, 32'h3000);
        chk("t3_head_instr", out_instr, ~32'h3000);
        chk("t3_head_count", count, 1);
        @(negedge clk);
        for (int c = 8; c <= 11; c++) begin
            #1;
            chk("t3_addr", icache_addr, 32'h3000 + 4 * (c - 5));
            @(negedge clk);
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Five-cycle stall mid-stream with ignored redirect/ready pulses.
        begin_test(1'b1);
        for (int i = 0; i < 7; i++) exp_q.push_back(32'h2000 + 4 * i);
        repeat (5) @(negedge clk);
        for (int c = 6; c <= 10; c++) begin
            stall = 1'b1;
            redirect_valid = (c == 7);
            redirect_pc = 32'h4000;
            out_ready = (c != 8);
            #1;
            chk("t4_stall_re", icache_re, 0);
            chk("t4_stall_count", count, 1);
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_pc", out_pc, 32'h200C);
            @(negedge clk);
        end
        stall = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("t4_rel_re", icache_re, 1);
        chk("t4_rel_addr", icache_addr, 32'h2014);
        chk("t4_rel_count", count, 1);
        @(negedge clk);
        #1;
        chk("t4_held_pc", out_pc, 32'h2010);
        chk("t4_held_instr", out_instr, ~32'h2010);
        @(negedge clk);
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-stream with two queued entries.
        begin_test(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h2000 + 4 * i);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_pre_count", count, 2);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_count", count, 0);
        chk("t6_async_re", icache_re, 0);
        chk("t6_async_addr", icache_addr, 32'h2000);
        chk("t6_async_pc", out_pc, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("t6_addr", icache_addr, 32'h2000 + 4 * (c - 1));
            chk("t6_re", icache_re, 1);
            @(negedge clk);
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
